// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC constants: instruction field positions, PC stepping and reset vector.
package kgp_risc_pkg;
  localparam int          INSTR_W          = 32;
  localparam int          OPCODE_MSB       = 31;
  localparam int          OPCODE_LSB       = 26;
  localparam int          FUNC_MSB         = 5;
  localparam int          FUNC_LSB         = 0;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_issue_unit_instr_fifo.sv
// Show-ahead synchronous FIFO; head is visible combinationally, zero-cycle read.
// Push on full and pop on empty are ignored; flush empties it in one edge and beats push/pop.
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign doPush   = push && (count != CNT_W'(DEPTH));
  assign doPop    = pop && (count != '0);
  assign headData = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/fetch_issue_unit.sv
// Instruction fetch front end: 1-cycle imem, prefetch FIFO, valid/ready issue; first issue 2 cycles after request.
// Requests stop when FIFO plus in-flight fetch fill DEPTH; redirect or rst flushes everything and restarts fetch.
module fetch_issue_unit
  import kgp_risc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              issue_ready,
  output logic              issue_valid,
  output logic [31:0]       issue_instr,
  output logic [ADDR_W-1:0] issue_pc,
  output logic [5:0]        OpCode,
  output logic [5:0]        FuncCode
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflightPc;
  logic               inflight;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] headData;
  logic [ADDR_W-1:0]  redirectAligned;
  logic [CNT_W:0]     credit;

  assign redirectAligned = redirect_pc & ~ADDR_W'(3);

  // The in-flight fetch already owns a FIFO slot; a same-cycle pop is not credited.
  assign credit    = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight);
  assign imem_en   = !rst && !redirect_valid && (credit < (CNT_W + 1)'(DEPTH));
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirectAligned;
      inflight <= 1'b0;
    end else if (imem_en) begin
      pc         <= pc + ADDR_W'(PC_STEP);
      inflight   <= 1'b1;
      inflightPc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  instr_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (inflight),
    .pushData ({inflightPc, imem_rdata}),
    .pop      (issue_valid && issue_ready),
    .headData (headData),
    .count    (count)
  );

  assign issue_valid = (count != '0);
  assign issue_instr = headData[INSTR_W-1:0];
  assign issue_pc    = headData[INSTR_W +: ADDR_W];
  assign OpCode      = issue_instr[OPCODE_MSB:OPCODE_LSB];
  assign FuncCode    = issue_instr[FUNC_MSB:FUNC_LSB];
endmodule
